// File: rtl/ibex_rvfi_trace_buffer_pkg.sv
// Shared types for the RVFI trace buffer: capture modes, FSM states and the 103-bit record layout.
// No logic; imported by the ring, the interface and the top.
package ibex_trace_pkg;

  typedef enum logic [1:0] {
    TM_CONT       = 2'd0,
    TM_TRIG_STOP  = 2'd1,
    TM_TRIG_START = 2'd2
  } trace_mode_e;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_ARMED = 2'd1,
    TS_POST  = 2'd2,
    TS_DONE  = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic        trap;
    logic        intr;
    logic [4:0]  rd_addr;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
  } trace_rec_t;

  localparam int unsigned TraceRecW = $bits(trace_rec_t);

  // The reserved encoding falls back to continuous capture.
  function automatic trace_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return TM_TRIG_STOP;
      2'd2:    return TM_TRIG_START;
      default: return TM_CONT;
    endcase
  endfunction

endpackage

// File: rtl/ibex_rvfi_trace_buffer_if.sv
// RVFI retirement tap plus the record read port (valid/ready) of the trace buffer.
// master drives retirements and rd_ready_i; slave is the buffer.
interface ibex_rvfi_trace_buffer_if;
  import ibex_trace_pkg::*;

  logic                 rvfi_valid;
  logic                 rvfi_trap;
  logic                 rvfi_intr;
  logic [31:0]          rvfi_insn;
  logic [31:0]          rvfi_pc_rdata;
  logic [4:0]           rvfi_rd_addr;
  logic [31:0]          rvfi_rd_wdata;
  logic                 rd_valid_o;
  logic                 rd_ready_i;
  logic [TraceRecW-1:0] rd_data_o;

  modport master (
    output rvfi_valid, rvfi_trap, rvfi_intr, rvfi_insn, rvfi_pc_rdata, rvfi_rd_addr,
           rvfi_rd_wdata, rd_ready_i,
    input  rd_valid_o, rd_data_o
  );

  modport slave (
    input  rvfi_valid, rvfi_trap, rvfi_intr, rvfi_insn, rvfi_pc_rdata, rvfi_rd_addr,
           rvfi_rd_wdata, rd_ready_i,
    output rd_valid_o, rd_data_o
  );

endinterface

// File: rtl/ibex_rvfi_trace_buffer_ring.sv
// Depth-entry record ring with count, overwrite-on-full option and registered head-of-queue data.
// Count and read data update one cycle after push/pop; a push to a full ring without pop/overwrite is discarded.
module ibex_trace_ring
  import ibex_trace_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   overwrite_i,
  input  logic                   pop_i,
  input  logic [TraceRecW-1:0]   wdata_i,
  output logic [TraceRecW-1:0]   rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

  logic [TraceRecW-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]        count_q, count_d;
  logic                 do_push, do_pop, ovr;

  assign full_o  = (count_q == FullCnt);
  assign count_o = count_q;

  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & (~full_o | do_pop | overwrite_i);
    ovr      = do_push & full_o & ~do_pop;
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop | ovr);
    count_d  = count_q;
    if (do_push && !do_pop && !ovr) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PtrW+1)'(1);
    end
    if (flush_i) begin
      do_push  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // Head register forwards a write that lands on the new head (ring was empty or drained to it).
  always_ff @(posedge clk_i) begin
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      rdata_o <= wdata_i;
    end else begin
      rdata_o <= mem[rd_ptr_d];
    end
  end

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// Synthesisable RVFI trace capture: continuous, trigger-stop and trigger-start modes over a ring buffer.
// Records drain over valid/ready; in trigger modes reads open only once capture is done.
module ibex_rvfi_trace_buffer
  import ibex_trace_pkg::*;
#(
  parameter int unsigned Depth           = 16,
  parameter int unsigned PostTrigDefault = 8,
  parameter int unsigned DropCntW        = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ibex_rvfi_trace_buffer_if.slave bus,
  input  logic [1:0]             mode_i,
  input  logic                   arm_i,
  input  logic                   clear_i,
  input  logic [31:0]            trig_pc_i,
  input  logic                   trig_on_trap_i,
  input  logic [$clog2(Depth):0] post_cnt_i,
  output logic [$clog2(Depth):0] count_o,
  output logic                   triggered_o,
  output logic                   done_o,
  output logic [DropCntW-1:0]    drop_cnt_o
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  localparam logic [1:0] ST_IDLE  = TS_IDLE;
  localparam logic [1:0] ST_ARMED = TS_ARMED;
  localparam logic [1:0] ST_POST  = TS_POST;
  localparam logic [1:0] ST_DONE  = TS_DONE;

  logic [1:0]          state_q, state_d;
  trace_mode_e         mode_q;
  logic                triggered_q;
  logic [CntW-1:0]     post_q;
  logic [DropCntW-1:0] drop_q;
  logic [CntW-1:0]     count;
  logic                full, push, overwrite, pop, flush, rd_valid, trig_hit, drop_ev;
  trace_rec_t          wrec;

  assign wrec.trap     = bus.rvfi_trap;
  assign wrec.intr     = bus.rvfi_intr;
  assign wrec.rd_addr  = bus.rvfi_rd_addr;
  assign wrec.pc       = bus.rvfi_pc_rdata;
  assign wrec.insn     = bus.rvfi_insn;
  assign wrec.rd_wdata = bus.rvfi_rd_wdata;

  assign trig_hit = bus.rvfi_valid &
                    ((bus.rvfi_pc_rdata == trig_pc_i) | (trig_on_trap_i & bus.rvfi_trap));
  assign flush    = clear_i | arm_i;
  assign rd_valid = (count != '0) & ((mode_q == TM_CONT) | (state_q == ST_DONE));
  assign pop      = rd_valid & bus.rd_ready_i & ~flush;
  assign drop_ev  = (state_q == ST_ARMED) & (mode_q == TM_CONT) & bus.rvfi_valid &
                    full & ~pop & ~flush;

  always_comb begin
    push      = 1'b0;
    overwrite = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_ARMED: begin
        case (mode_q)
          TM_TRIG_STOP: begin
            push      = bus.rvfi_valid;
            overwrite = 1'b1;
            if (trig_hit) state_d = (post_q == '0) ? ST_DONE : ST_POST;
          end
          TM_TRIG_START: begin
            // Nothing is stored until the trigger record itself arrives.
            push = triggered_q ? bus.rvfi_valid : trig_hit;
            if (push && (count == CntW'(Depth - 1))) state_d = ST_DONE;
          end
          default: push = bus.rvfi_valid;
        endcase
      end
      ST_POST: begin
        push      = bus.rvfi_valid;
        overwrite = 1'b1;
        if (bus.rvfi_valid && (post_q == CntW'(1))) state_d = ST_DONE;
      end
      default: ;
    endcase
    if (flush) begin
      push    = 1'b0;
      state_d = clear_i ? ST_IDLE : ST_ARMED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= TM_CONT;
      triggered_q <= 1'b0;
      post_q      <= CntW'(PostTrigDefault);
      drop_q      <= '0;
    end else begin
      state_q <= state_d;
      if (clear_i) begin
        triggered_q <= 1'b0;
        drop_q      <= '0;
      end else if (arm_i) begin
        triggered_q <= 1'b0;
        drop_q      <= '0;
        post_q      <= post_cnt_i;
        mode_q      <= decode_mode(mode_i);
      end else begin
        if (trig_hit && (state_q == ST_ARMED) && (mode_q != TM_CONT)) triggered_q <= 1'b1;
        if ((state_q == ST_POST) && bus.rvfi_valid) post_q <= post_q - CntW'(1);
        if (drop_ev && (drop_q != '1)) drop_q <= drop_q + DropCntW'(1);
      end
    end
  end

  ibex_trace_ring #(
    .Depth (Depth)
  ) u_ring (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .push_i      (push),
    .overwrite_i (overwrite),
    .pop_i       (pop),
    .wdata_i     (wrec),
    .rdata_o     (bus.rd_data_o),
    .count_o     (count),
    .full_o      (full)
  );

  assign bus.rd_valid_o = rd_valid;
  assign count_o        = count;
  assign triggered_o    = triggered_q;
  assign done_o         = (state_q == ST_DONE);
  assign drop_cnt_o     = drop_q;

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
Name: ibex_rvfi_trace_buffer

Overview:
- On-chip capture buffer for RVFI retirement records; sits beside ibex_top and taps the same rvfi_* signals as the simulation tracer.
- Unlike the text tracer, it is synthesisable: retired instructions go into a depth-parametrised ring buffer.
- Three capture modes: continuous FIFO, trigger-stop (flight recorder) and trigger-start.
- Records drain over a valid/ready read port to a debug/bus adapter.

Parameters:
- Depth, 16: buffer entries; power of two, >=2.
- PostTrigDefault, 8: reset value of the post-trigger count register.
- DropCntW, 16: width of the saturating dropped-record counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- rvfi_valid  in  1  retirement strobe.
- rvfi_trap  in  1  retired instruction trapped.
- rvfi_intr  in  1  first instruction of a trap handler.
- rvfi_insn  in  32  instruction word.
- rvfi_pc_rdata  in  32  PC of the retired instruction.
- rvfi_rd_addr  in  5  destination register.
- rvfi_rd_wdata  in  32  destination write data.
- mode_i  in  2  0=CONT, 1=TRIG_STOP, 2=TRIG_START, 3=reserved (treated as CONT).
- arm_i  in  1  pulse: clear buffer and start a capture.
- clear_i  in  1  pulse: flush and return to IDLE.
- trig_pc_i  in  32  trigger PC.
- trig_on_trap_i  in  1  rvfi_trap also fires the trigger.
- post_cnt_i  in  $clog2(Depth)+1  records captured after the trigger in TRIG_STOP; sampled on arm_i.
- rd_valid_o  out  1  record available.
- rd_ready_i  in  1  consumer accepts the record.
- rd_data_o  out  103  {trap, intr, rd_addr[4:0], pc[31:0], insn[31:0], rd_wdata[31:0]}, MSB first.
- count_o  out  $clog2(Depth)+1  entries held.
- triggered_o  out  1  trigger has fired since arm.
- done_o  out  1  capture complete.
- drop_cnt_o  out  DropCntW  saturating count of records lost.

Behaviour:
- Reset (rst_ni low at posedge): state=IDLE; pointers, count, drop_cnt=0; post register=PostTrigDefault.
- Reset drives all outputs low/zero except rd_data_o, which is don't-care while rd_valid_o=0.
- Capture event: rvfi_valid=1 in a capturing state. The record is written at the edge it is presented and is visible on count_o next cycle.
- Trigger condition: rvfi_valid & (rvfi_pc_rdata==trig_pc_i | (trig_on_trap_i & rvfi_trap)).
- FSM states: IDLE, ARMED, POST, DONE.
- IDLE: nothing captured. arm_i -> flush pointers, count, drop_cnt and triggered, latch post_cnt_i, go to ARMED.
- ARMED, CONT mode:
  - Capture every event.
  - If full and no pop in the same cycle, drop the record and increment drop_cnt (saturates at all-ones).
  - Full with a simultaneous pop: push and pop both take effect; count unchanged.
  - Never leaves ARMED except via clear_i or re-arm.
- ARMED, TRIG_STOP mode:
  - Capture every event into the ring; when full, overwrite the oldest (rd_ptr advances with wr_ptr). Overwrites are not drops.
  - On trigger: store the trigger record, set triggered_o. If latched post count==0 go to DONE, else go to POST.
- POST: capture each event and decrement the post counter; the transition to DONE happens on the event that brings it to 0. Overwrite rules are as in ARMED.
- ARMED, TRIG_START mode:
  - Ignore events until trigger; the trigger record is the first entry stored and sets triggered_o.
  - Capture subsequent events until count==Depth, then go to DONE. Further events are ignored (not drops).
- DONE: done_o=1; no capture.
- Read port, TRIG modes: read permitted only in DONE. rd_valid_o = (count!=0) & (state==DONE).
- Read port, CONT mode: rd_valid_o = count!=0.
- Handshake: rd_data_o is the oldest record and must be stable while rd_valid_o & !rd_ready_i. A pop occurs on rd_valid_o & rd_ready_i.
- Register rd_data_o from the storage read; zero-cycle bypass of a same-cycle write is not required.
- count_o always reflects pushes and pops with 1-cycle latency.
- clear_i: go to IDLE and flush; it has priority over arm_i and any capture in the same cycle.
- arm_i while not IDLE: acts as clear followed by arm (single cycle, re-arm).
- mode_i: sampled only on arm_i. Changes mid-capture are ignored.
- Pointers: $clog2(Depth) bits, natural wrap.

Decomposition:
- ibex_trace_pkg holds:
  - trace_mode_e (CONT/TRIG_STOP/TRIG_START);
  - trace_rec_t packed struct (103 bits);
  - TraceRecW constant;
  - trace_state_e.
- One sub-module, ibex_trace_ring: Depth x TraceRecW storage with wr/rd pointers, count, push/pop/overwrite/flush inputs and registered read data.
- The top module holds the FSM, trigger compare, post counter and drop counter.

Test Plan:
- CONT, Depth=16, rd_ready_i=0, 20 retirements -> count_o=16, drop_cnt_o=4; then drain -> 16 records in order, PCs of events 0..15.
- CONT, full, retire and pop in the same cycle every cycle for 10 cycles -> count_o stays 16, drop_cnt_o unchanged.
- TRIG_STOP, post_cnt_i=4, trig_pc_i=0x100, 30 retirements with PC 0x100 at event 20 -> done_o after event 24; drain yields events 9..24, trigger is 12th record.
- TRIG_START, trig_on_trap_i=1, rvfi_trap at event 5 of 40 -> first record is event 5; done_o after event 20; count_o=16; events 21+ ignored; drop_cnt_o=0.
- Mid-capture in TRIG_STOP: assert clear_i and arm_i in the same cycle, then deassert rst_ni for 1 cycle -> IDLE, count_o=0, triggered_o=0, rd_valid_o=0 after each.
- TRIG_STOP, read attempt before trigger with rd_ready_i=1 -> rd_valid_o=0 and count unchanged until DONE.
